// File: rtl/instr_fetch_pkg.sv
// ============================================================================
//  Module  : instr_fetch_pkg
//  Brief   : Shared RISC-V ISA constants and helpers for the fetch slice.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package instr_fetch_pkg;

    localparam int          XLEN = 32;
    localparam int          ILEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    // Circular-buffer pointer advance for buffers whose depth need not be a power of two.
    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
//  Module  : fetch_fifo
//  Brief   : Synchronous instruction buffer (word + PC) with flush.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int DW    = ILEN,
    parameter int AW    = 32,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic [AW-1:0] push_pc,
    input  logic          pop,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] rd_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] r_data [DEPTH];
    logic [AW-1:0] r_pc   [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          w_pop;

    // The producer only pushes when a slot is guaranteed, so push needs no full check.
    assign w_pop = pop && (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_data[r_wp] <= push_data;
            r_pc[r_wp]   <= push_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (push)
                r_wp <= PW'(ptr_next(int'(r_wp), DEPTH));
            if (w_pop)
                r_rp <= PW'(ptr_next(int'(r_rp), DEPTH));
            case ({push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign empty   = (r_cnt == '0);
    assign count   = r_cnt;
    assign rd_data = empty ? '0 : r_data[r_rp];
    assign rd_pc   = empty ? '0 : r_pc[r_rp];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
//  Module  : instr_fetch
//  Brief   : Credit-based instruction fetch with redirect and stale-drop.
//            Optional misaligned-target trap: define IFETCH_MISALIGN_EXC_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter int              XLEN       = instr_fetch_pkg::XLEN,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic [XLEN-1:0]                 mem_req_addr,
    input  logic                            mem_rsp_valid,
    input  logic [instr_fetch_pkg::ILEN-1:0] mem_rsp_data,
    input  logic                            redirect_valid,
    input  logic [XLEN-1:0]                 redirect_pc,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [instr_fetch_pkg::ILEN-1:0] out_instr,
    output logic [XLEN-1:0]                 out_pc,
    output logic                            fetch_exception
);

    import instr_fetch_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = CW + 2;

    logic [XLEN-1:0] r_fpc;
    logic [XLEN-1:0] w_redir_pc;
    logic [CW-1:0]   r_outst;
    logic [CW-1:0]   r_drop;
    logic [CW-1:0]   w_fifo_cnt;
    logic [XLEN-1:0] r_pcq [FIFO_DEPTH];
    logic [PW-1:0]   r_pcq_wp;
    logic [PW-1:0]   r_pcq_rp;
    logic [SW-1:0]   w_busy;
    logic            w_exc;
    logic            w_acc;
    logic            w_pop;
    logic            w_stale;
    logic            w_live;
    logic            w_req_ok;
    logic            w_fifo_empty;

    // Stale in-flight responses still hold a credit so the drop counter can never
    // outgrow its width; a same-cycle pop returns its credit for full throughput.
    assign w_busy        = SW'(r_outst) + SW'(r_drop) + SW'(w_fifo_cnt);
    assign w_pop         = out_valid && out_ready && !redirect_valid;
    assign w_req_ok      = w_busy < (SW'(FIFO_DEPTH) + SW'(w_pop));
    assign mem_req_valid = !rst && !w_exc && w_req_ok;
    assign mem_req_addr  = r_fpc;
    assign w_acc         = mem_req_valid && mem_req_ready;
    assign w_stale       = mem_rsp_valid && ((r_drop != '0) || redirect_valid);
    assign w_live        = mem_rsp_valid && !w_stale;
    assign out_valid     = !w_fifo_empty;

`ifdef IFETCH_MISALIGN_EXC_EN
    logic r_exc;

    assign w_redir_pc = redirect_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_exc <= 1'b0;
        else if (redirect_valid)
            r_exc <= |redirect_pc[1:0];
    end

    assign w_exc = r_exc;
`else
    assign w_redir_pc = redirect_pc & ~XLEN'(3);
    assign w_exc      = 1'b0;
`endif

    assign fetch_exception = w_exc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_fpc <= RESET_PC;
        else if (redirect_valid)
            r_fpc <= w_redir_pc;
        else if (w_acc)
            r_fpc <= r_fpc + XLEN'(4);
    end

    // On redirect every live request (plus one accepted now) becomes stale; a
    // response arriving in that same cycle is one of them and is retired at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outst <= '0;
            r_drop  <= '0;
        end else if (redirect_valid) begin
            r_outst <= '0;
            r_drop  <= r_drop + r_outst + CW'(w_acc) - CW'(mem_rsp_valid);
        end else begin
            r_outst <= r_outst + CW'(w_acc) - CW'(w_live);
            if (w_stale)
                r_drop <= r_drop - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc && !redirect_valid)
            r_pcq[r_pcq_wp] <= r_fpc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pcq_wp <= '0;
            r_pcq_rp <= '0;
        end else if (redirect_valid) begin
            r_pcq_wp <= '0;
            r_pcq_rp <= '0;
        end else begin
            if (w_acc)
                r_pcq_wp <= PW'(ptr_next(int'(r_pcq_wp), FIFO_DEPTH));
            if (w_live)
                r_pcq_rp <= PW'(ptr_next(int'(r_pcq_rp), FIFO_DEPTH));
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DW    (ILEN),
        .AW    (XLEN),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_live),
        .push_data (mem_rsp_data),
        .push_pc   (r_pcq[r_pcq_rp]),
        .pop       (w_pop),
        .empty     (w_fifo_empty),
        .count     (w_fifo_cnt),
        .rd_data   (out_instr),
        .rd_pc     (out_pc)
    );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
//  Module  : tb_instr_fetch
//  Brief   : Scoreboard bench for instr_fetch with a queue-based memory model.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    import instr_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_exception;

    always #5 clk = ~clk;

    instr_fetch #(
        .XLEN       (32),
        .FIFO_DEPTH (2),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc),
        .fetch_exception (fetch_exception)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mq[$];
    logic [31:0] acc_log[$];
    int          n_pass = 0;
    int          n_chk = 0;
    int          cyc = 0;
    int          last_pop = -1;
    int          first_pop = -1;
    int          n_acc = 0;
    int          acc_snap = 0;
    bit          rsp_en = 1'b1;
    bit          auto_rdy = 1'b1;
    bit          chk_tput = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic expect_pc(input logic [31:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = mem_word(a);
        exp_q.push_back(e);
    endtask

    // One clock cycle: called at a negedge, returns at the next negedge.
    task automatic step_full(input bit redir, input logic [31:0] rpc, input bit rdy);
        logic [31:0] a;
        cyc++;
        redirect_valid = redir;
        redirect_pc    = rpc;
        mem_req_ready  = rdy;
        if (rsp_en && mq.size() != 0) begin
            a             = mq.pop_front();
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(a);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
        if (auto_rdy)
            out_ready = (exp_q.size() != 0);
        #1;
        if (mem_req_valid && mem_req_ready) begin
            mq.push_back(mem_req_addr);
            acc_log.push_back(mem_req_addr);
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic step();
        step_full(1'b0, 32'h0, 1'b1);
    endtask

    task automatic run_drain(input string name, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            step();
            k++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b1;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        out_ready      = 1'b0;
        mq.delete();
        exp_q.delete();
        acc_log.delete();
        rsp_en    = 1'b1;
        auto_rdy  = 1'b1;
        chk_tput  = 1'b0;
        last_pop  = -1;
        first_pop = -1;
        n_acc     = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = -1;
    endtask

    // Monitor: compares every completed handshake against the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_output: got pc %h, expected no output", out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_pc", out_pc, mon_e.pc);
                check("out_instr", out_instr, mon_e.instr);
                if (chk_tput && last_pop >= 0)
                    check("out_gap", 32'(cyc - last_pop), 32'd1);
                if (first_pop < 0)
                    first_pop = cyc;
                last_pop = cyc;
            end
        end
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst_req_addr", mem_req_addr, 32'h0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_exception", {31'd0, fetch_exception}, 32'd0);

        // Streaming, 1-cycle memory, decode always ready
        do_reset();
        chk_tput = 1'b1;
        for (int i = 0; i < 8; i++)
            expect_pc(32'(i * 4));
        step();
        check("first_req_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF, 32'h0);
        run_drain("stream", 40);
        check("first_out_cycle", 32'(first_pop), 32'd2);
        chk_tput = 1'b0;

        // Decode stalled: credits cap requests at FIFO_DEPTH
        do_reset();
        auto_rdy  = 1'b0;
        out_ready = 1'b0;
        repeat (10) step();
        check("stall_accepts", 32'(n_acc), 32'd2);
        check("stall_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 6; i++)
            expect_pc(32'(i * 4));
        auto_rdy = 1'b1;
        run_drain("stall_release", 40);

        // Redirect with two requests outstanding
        do_reset();
        rsp_en = 1'b0;
        repeat (4) step();
        check("redir_outstanding", 32'(n_acc), 32'd2);
        check("redir_req_blocked", {31'd0, mem_req_valid}, 32'd0);
        step_full(1'b1, 32'h100, 1'b1);
        expect_pc(32'h100);
        expect_pc(32'h104);
        expect_pc(32'h108);
        rsp_en = 1'b1;
        run_drain("redirect", 40);

        // Redirect coinciding with an accepted request and a response
        do_reset();
        rsp_en = 1'b0;
        step_full(1'b0, 32'h0, 1'b1);
        step_full(1'b0, 32'h0, 1'b0);
        check("hold_valid", {31'd0, mem_req_valid}, 32'd1);
        check("hold_addr", mem_req_addr, 32'h4);
        rsp_en = 1'b1;
        step_full(1'b1, 32'h40, 1'b1);
        check("same_cycle_acc", 32'(n_acc), 32'd2);
        check("same_cycle_empty", {31'd0, out_valid}, 32'd0);
        expect_pc(32'h40);
        expect_pc(32'h44);
        run_drain("same_cycle", 40);

        // Address wrap at the top of the space
        do_reset();
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000);
        expect_pc(32'h0000_0004);
        step_full(1'b1, 32'hFFFF_FFFC, 1'b1);
        run_drain("wrap", 40);
        check("wrap_top_addr", (acc_log.size() > 1) ? acc_log[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_next_addr", (acc_log.size() > 2) ? acc_log[2] : 32'hDEAD_BEEF, 32'h0);

        // Misaligned redirect target
        do_reset();
`ifdef IFETCH_MISALIGN_EXC_EN
        step_full(1'b1, 32'h102, 1'b1);
        check("misalign_exc_set", {31'd0, fetch_exception}, 32'd1);
        acc_snap = n_acc;
        repeat (4) step();
        check("misalign_no_req", 32'(n_acc), 32'(acc_snap));
        check("misalign_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("misalign_out_valid", {31'd0, out_valid}, 32'd0);
        check("misalign_exc_sticky", {31'd0, fetch_exception}, 32'd1);
        expect_pc(32'h200);
        expect_pc(32'h204);
        step_full(1'b1, 32'h200, 1'b1);
        check("misalign_exc_clear", {31'd0, fetch_exception}, 32'd0);
        run_drain("misalign_resume", 40);
`else
        expect_pc(32'h100);
        expect_pc(32'h104);
        step_full(1'b1, 32'h102, 1'b1);
        check("misalign_exc_tied", {31'd0, fetch_exception}, 32'd0);
        run_drain("misalign_forced", 40);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
